// File: rtl/lcd_gfx_pkg.sv
// Shared definitions for the ST7920-class graphic LCD refresh controller:
// controller state encoding, instruction bytes and GDRAM address helpers.
package lcd_gfx_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_FUNC0,
    ST_ENTRY,
    ST_DISP,
    ST_FUNC1,
    ST_SET_Y,
    ST_SET_X,
    ST_WRITE,
    ST_FRAME_END
  } lcd_state_t;

  // Basic instruction set, 8-bit interface
  localparam logic [7:0] CMD_FUNC_BASIC   = 8'h30;
  // Cursor increments, no display shift
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  // Display on, cursor and blink off
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  // Extended instruction set with graphics display enabled
  localparam logic [7:0] CMD_FUNC_EXT_GFX = 8'h36;
  // GDRAM address command base (Y first, then X)
  localparam logic [7:0] CMD_ADDR_BASE    = 8'h80;

  // Vertical GDRAM address: the panel folds 64 rows into 32 Y lines
  function automatic logic [7:0] gdram_y_cmd(input logic [4:0] row_lo);
    return CMD_ADDR_BASE | {3'b000, row_lo};
  endfunction

  // Horizontal GDRAM address: rows 32..63 live in the second half (X=8)
  function automatic logic [7:0] gdram_x_cmd(input logic lower_bank);
    return CMD_ADDR_BASE | {4'b0000, lower_bank, 3'b000};
  endfunction

endpackage

// File: rtl/lcd_step_gen.sv
// LCD timing divider: a phase bit that toggles every CLK_DIV clocks and a
// one-clock step strobe on each low-to-high phase transition.
module lcd_step_gen #(
  parameter int CLK_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  output logic phase,
  output logic step
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_LAST);
  // step coincides with the edge that raises phase, so a byte issued on
  // step gets the high half-period first and the falling edge mid-byte
  assign step = wrap & ~phase;

  // Free-running half-period counter and phase toggle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd_gfx_refresh_ctrl.sv
// Graphic LCD refresh controller: runs the panel init sequence once after
// reset, then streams a frame buffer from synchronous memory into GDRAM one
// pixel row at a time, single-shot or continuously.
module lcd_gfx_refresh_ctrl
  import lcd_gfx_pkg::*;
#(
  parameter int CLK_DIV       = 2500,
  parameter int ROWS          = 64,
  parameter int BYTES_PER_ROW = 16,
  parameter int ADDR_W        = 10,
  parameter int RD_LAT        = 1,
  parameter int PWRUP_STEPS   = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              rs,
  output logic              rw,
  output logic              en,
  output logic [7:0]        data
);

  localparam int COL_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
  localparam int PW_W  = (PWRUP_STEPS > 1) ? $clog2(PWRUP_STEPS + 1) : 1;

  localparam logic [5:0]       ROW_LAST   = 6'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(BYTES_PER_ROW - 1);
  localparam logic [PW_W-1:0]  PWRUP_LAST = PW_W'(PWRUP_STEPS - 1);
  // A 32-row panel only uses the upper GDRAM bank
  localparam logic             HAS_LOWER  = (ROWS == 64);

  // Parameter legality, caught at elaboration
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if (ROWS != 32 && ROWS != 64) begin : g_bad_rows
    $error("ROWS must be 32 or 64");
  end
  if (RD_LAT >= 2 * CLK_DIV) begin : g_bad_rd_lat
    $error("RD_LAT must be below one LCD step period");
  end
  if ((1 << ADDR_W) < ROWS * BYTES_PER_ROW) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the frame buffer");
  end
  if (PWRUP_STEPS < 1) begin : g_bad_pwrup
    $error("PWRUP_STEPS must be at least 1");
  end

  logic phase;
  logic step;

  lcd_step_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_step_gen (
    .clk   (clk),
    .rst   (rst),
    .phase (phase),
    .step  (step)
  );

  lcd_state_t        state,    state_nxt;
  logic [PW_W-1:0]   pwr_cnt,  pwr_cnt_nxt;
  logic [5:0]        row,      row_nxt;
  logic [COL_W-1:0]  col,      col_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              rs_nxt;
  logic [7:0]        data_nxt;
  logic              issuing,  issuing_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              cont_q,   cont_nxt;
  logic              inited,   inited_nxt;

  // The write path only ever sees the panel as write-only
  assign rw = 1'b0;
  // Strobe is the divider phase gated by "a byte is on the bus"; being
  // combinational from reset registers it drops the instant rst asserts
  assign en = phase & issuing;

  // State and datapath registers; everything resets so a mid-frame reset
  // restores the idle bus and forces the init sequence to rerun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_PWRUP;
      pwr_cnt  <= '0;
      row      <= '0;
      col      <= '0;
      mem_addr <= '0;
      rs       <= 1'b0;
      data     <= 8'h00;
      issuing  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cont_q   <= 1'b0;
      inited   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pwr_cnt  <= pwr_cnt_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      mem_addr <= addr_nxt;
      rs       <= rs_nxt;
      data     <= data_nxt;
      issuing  <= issuing_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      cont_q   <= cont_nxt;
      inited   <= inited_nxt;
    end
  end

  // Next-state and bus decisions, evaluated only on LCD step strobes
  always_comb begin
    state_nxt   = state;
    pwr_cnt_nxt = pwr_cnt;
    row_nxt     = row;
    col_nxt     = col;
    addr_nxt    = mem_addr;
    rs_nxt      = rs;
    data_nxt    = data;
    issuing_nxt = issuing;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    cont_nxt    = cont_q;
    inited_nxt  = inited;

    if (step) begin
      unique case (state)
        ST_PWRUP: begin
          issuing_nxt = 1'b0;
          if (pwr_cnt == PWRUP_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            pwr_cnt_nxt = pwr_cnt + PW_W'(1);
          end
        end

        ST_IDLE: begin
          rs_nxt      = 1'b0;
          data_nxt    = 8'h00;
          issuing_nxt = 1'b0;
          if (start) begin
            busy_nxt  = 1'b1;
            cont_nxt  = cont;
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = inited ? ST_SET_Y : ST_FUNC0;
          end
        end

        ST_FUNC0: begin
          rs_nxt      = 1'b0;
          data_nxt    = CMD_FUNC_BASIC;
          issuing_nxt = 1'b1;
          state_nxt   = ST_ENTRY;
        end

        ST_ENTRY: begin
          rs_nxt      = 1'b0;
          data_nxt    = CMD_ENTRY_MODE;
          issuing_nxt = 1'b1;
          state_nxt   = ST_DISP;
        end

        ST_DISP: begin
          rs_nxt      = 1'b0;
          data_nxt    = CMD_DISP_ON;
          issuing_nxt = 1'b1;
          state_nxt   = ST_FUNC1;
        end

        ST_FUNC1: begin
          rs_nxt      = 1'b0;
          data_nxt    = CMD_FUNC_EXT_GFX;
          issuing_nxt = 1'b1;
          inited_nxt  = 1'b1;
          state_nxt   = ST_SET_Y;
        end

        ST_SET_Y: begin
          rs_nxt      = 1'b0;
          data_nxt    = gdram_y_cmd(row[4:0]);
          issuing_nxt = 1'b1;
          state_nxt   = ST_SET_X;
        end

        ST_SET_X: begin
          // Present the row base address a full step before the first
          // WRITE so the memory has RD_LAT clocks to answer
          rs_nxt      = 1'b0;
          data_nxt    = gdram_x_cmd(row[5] & HAS_LOWER);
          issuing_nxt = 1'b1;
          addr_nxt    = ADDR_W'(row * BYTES_PER_ROW);
          state_nxt   = ST_WRITE;
        end

        ST_WRITE: begin
          rs_nxt      = 1'b1;
          data_nxt    = mem_data;
          issuing_nxt = 1'b1;
          if (col == COL_LAST) begin
            col_nxt = '0;
            if (row == ROW_LAST) begin
              // Wrap instead of stepping past the end of the frame buffer
              row_nxt   = '0;
              addr_nxt  = '0;
              state_nxt = ST_FRAME_END;
            end else begin
              row_nxt   = row + 6'd1;
              addr_nxt  = mem_addr + ADDR_W'(1);
              state_nxt = ST_SET_Y;
            end
          end else begin
            col_nxt  = col + COL_W'(1);
            addr_nxt = mem_addr + ADDR_W'(1);
          end
        end

        ST_FRAME_END: begin
          rs_nxt      = 1'b0;
          data_nxt    = 8'h00;
          issuing_nxt = 1'b0;
          done_nxt    = 1'b1;
          // Keep going only if continuous mode was latched at frame start
          // and is still requested now, so dropping cont mid-frame ends
          // the run after the current frame
          if (cont_q && cont) begin
            row_nxt   = '0;
            col_nxt   = '0;
            cont_nxt  = cont;
            state_nxt = ST_SET_Y;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          issuing_nxt = 1'b0;
          state_nxt   = ST_PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_gfx_refresh_ctrl.sv
// Bench for lcd_gfx_refresh_ctrl: random frame-buffer contents behind a
// fixed-latency memory model; LCD bytes captured on each en falling edge and
// compared with a frame stream built directly from the panel command rules.
module tb_lcd_gfx_refresh_ctrl;

  localparam int CLK_DIV = 4;
  localparam int ROWS    = 64;
  localparam int BPR     = 16;
  localparam int ADDR_W  = 10;
  localparam int RD_LAT  = 3;
  localparam int PWRUP   = 3;
  localparam int STEP_T  = 2 * CLK_DIV;
  localparam int FRAME_B = ROWS * (BPR + 2);

  logic              clk;
  logic              rst;
  logic              start;
  logic              cont;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              rs;
  logic              rw;
  logic              en;
  logic [7:0]        data;

  lcd_gfx_refresh_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .ROWS          (ROWS),
    .BYTES_PER_ROW (BPR),
    .ADDR_W        (ADDR_W),
    .RD_LAT        (RD_LAT),
    .PWRUP_STEPS   (PWRUP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cont     (cont),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .rs       (rs),
    .rw       (rw),
    .en       (en),
    .data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got_v,
                           input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Frame buffer contents and a memory with RD_LAT clocks of read latency
  logic [7:0]        rom   [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] apipe [0:RD_LAT-1];

  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_data = rom[apipe[RD_LAT-1]];

  // Panel-side capture: the LCD latches {rs,data} on en falling
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit         en_prev;
  int         done_cnt = 0;
  int         rw_bad   = 0;
  int         addr_bad = 0;

  always @(negedge clk) begin
    if (en_prev && !en) got_q.push_back({rs, data});
    en_prev = en;
    if (done) done_cnt++;
    if (rw !== 1'b0) rw_bad++;
    if (mem_addr > ADDR_W'(ROWS * BPR - 1)) addr_bad++;
  end

  // Expected byte stream for one frame, from the panel addressing rules
  task automatic build_frame(input bit with_init);
    if (with_init) begin
      exp_q.push_back({1'b0, 8'h30});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h36});
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | 8'(r % 32)});
      exp_q.push_back({1'b0, (r >= 32) ? 8'h88 : 8'h80});
      for (int c = 0; c < BPR; c++) exp_q.push_back({1'b1, rom[r*BPR + c]});
    end
  endtask

  task automatic compare_stream(input string tag, input int upto);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    if (upto > 0) begin
      if (n > upto) n = upto;
    end else begin
      check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    end
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < limit);
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int limit);
    int k = 0;
    do begin @(negedge clk); k++; end while (!busy && k < limit);
    check_val({tag, "_busy_seen"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int limit);
    int k = 0;
    do begin @(negedge clk); k++; end while (got_q.size() < n && k < limit);
    check_val({tag, "_bytes_seen"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_en"},   32'(en),       32'd0);
    check_val({tag, "_busy"}, 32'(busy),     32'd0);
    check_val({tag, "_done"}, 32'(done),     32'd0);
    check_val({tag, "_rs"},   32'(rs),       32'd0);
    check_val({tag, "_data"}, 32'(data),     32'h00);
    check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    logic [8:0] b;

    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom);
    rst   = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Power-up wait: start held from reset release; expect PWRUP steps,
    // one IDLE step accepting start, then the first command strobe
    rst   = 1'b1;
    start = 1'b1;
    got_q.delete();
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!en && cyc < 400);
    check_val("pwrup_first_en_cycle", 32'(cyc), 32'(CLK_DIV + (PWRUP + 1) * STEP_T));
    start = 1'b0;
    exp_q.delete();
    build_frame(1'b1);
    d0 = done_cnt;
    wait_done("frame1", 12000);
    repeat (4) @(negedge clk);
    compare_stream("frame1", 0);
    check_val("frame1_busy_low", 32'(busy), 32'd0);
    check_val("frame1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Second single-shot frame: init must not repeat
    repeat ($urandom_range(5, 40)) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    build_frame(1'b0);
    d0 = done_cnt;
    start = 1'b1;
    wait_busy("frame2", 100);
    start = 1'b0;
    wait_done("frame2", 12000);
    repeat (4) @(negedge clk);
    b = (got_q.size() > 0) ? got_q[0] : 9'h1ff;
    check_val("frame2_first_byte", 32'(b), 32'h080);
    b = (got_q.size() > 32*18) ? got_q[32*18] : 9'h1ff;
    check_val("row32_y", 32'(b), 32'h080);
    b = (got_q.size() > 32*18 + 1) ? got_q[32*18 + 1] : 9'h1ff;
    check_val("row32_x", 32'(b), 32'h088);
    compare_stream("frame2", 0);
    check_val("frame2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_val("frame2_busy_low", 32'(busy), 32'd0);

    // Continuous mode: cont dropped part-way through the third frame
    repeat ($urandom_range(5, 40)) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 3; f++) build_frame(1'b0);
    d0 = done_cnt;
    cont  = 1'b1;
    start = 1'b1;
    wait_busy("cont", 100);
    start = 1'b0;
    wait_done("cont_f1", 12000);
    wait_done("cont_f2", 12000);
    repeat ($urandom_range(100, 5000)) @(negedge clk);
    cont = 1'b0;
    wait_done("cont_f3", 12000);
    repeat (3000) @(negedge clk);
    check_val("cont_done_pulses", 32'(done_cnt - d0), 32'd3);
    check_val("cont_busy_low", 32'(busy), 32'd0);
    compare_stream("cont", 0);

    // Asynchronous reset in the middle of row 10's data bytes
    repeat ($urandom_range(5, 40)) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    build_frame(1'b0);
    start = 1'b1;
    wait_busy("rst_mid", 100);
    start = 1'b0;
    wait_bytes("rst_mid", 10*18 + 2 + $urandom_range(1, 10), 4000);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(en && rs) && cyc < 100);
    check_val("rst_mid_write_active", 32'(en && rs), 32'd1);
    compare_stream("rst_mid_prefix", 10*18);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    got_q.delete();
    rst   = 1'b1;
    start = 1'b1;
    wait_busy("reinit", 200);
    start = 1'b0;
    wait_bytes("reinit", 4, 200);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h36});
    compare_stream("reinit", 4);

    check_val("rw_always_zero", 32'(rw_bad), 32'd0);
    check_val("addr_in_range", 32'(addr_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
